// File: rtl/lab4d_pkg.sv
// Shared LAB4D load-path definitions: select/data widths, select legality
// and the sequencer state encoding.
package lab4d_pkg;

    localparam int NUM_LAB   = 12;
    localparam int LAB_SEL_W = 4;
    localparam int LAB_DAT_W = 24;
    localparam int LAB_REQ_W = LAB_SEL_W + LAB_DAT_W;

    localparam logic [LAB_SEL_W-1:0] LAB_SEL_BCAST = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } seq_state_e;

    // Individual LABs 0..NUM_LAB-1 plus the broadcast code; the gap between is reserved.
    function automatic logic sel_legal(input logic [LAB_SEL_W-1:0] sel);
        return (sel < LAB_SEL_W'(NUM_LAB)) || (sel == LAB_SEL_BCAST);
    endfunction

endpackage

// File: rtl/lab4d_shift_sequencer_if.sv
// Request-side and shift-engine-side handshake of the LAB4D shift sequencer.
interface lab4d_shift_sequencer_if;
    import lab4d_pkg::*;

    logic                 wr_i;
    logic [LAB_SEL_W-1:0] wr_sel_i;
    logic [LAB_DAT_W-1:0] wr_dat_i;
    logic                 ready_o;

    logic                 go_o;
    logic [LAB_SEL_W-1:0] sel_o;
    logic [LAB_DAT_W-1:0] dat_o;
    logic                 busy_i;

    modport slave (
        input  wr_i, wr_sel_i, wr_dat_i, busy_i,
        output ready_o, go_o, sel_o, dat_o
    );

    modport master (
        output wr_i, wr_sel_i, wr_dat_i, busy_i,
        input  ready_o, go_o, sel_o, dat_o
    );

endinterface

// File: rtl/lab4d_req_fifo.sv
// First-word-fall-through request FIFO; head entry is visible on dout_o
// the cycle after it is pushed. Flush empties it on the same edge.
module lab4d_req_fifo
    import lab4d_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = LAB_REQ_W
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by the pointers/count, so it carries no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lab4d_shift_sequencer.sv
// Buffers LAB4D register-load requests and issues them one at a time to the
// serial shift engine, tracking the engine's busy handshake.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting for a queued entry and an idle engine
//   ST_WAIT_HI | go issued, waiting for busy_i to rise (bounded by timer)
//   ST_WAIT_LO | engine shifting, waiting for busy_i to fall
module lab4d_shift_sequencer
    import lab4d_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    lab4d_shift_sequencer_if.slave  bus,
    input  logic                    flush_i,
    input  logic                    clr_err_i,
    output logic                    idle_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    bad_sel_o,
    output logic                    overflow_o,
    output logic                    timeout_o
);

    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

    seq_state_e           state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 go_q, go_d;
    logic [LAB_SEL_W-1:0] sel_q, sel_d;
    logic [LAB_DAT_W-1:0] dat_q, dat_d;
    logic                 bad_sel_q, bad_sel_d;
    logic                 overflow_q, overflow_d;
    logic                 timeout_q, timeout_d;

    logic                 wr_legal;
    logic                 fifo_push, fifo_pop;
    logic                 fifo_full, fifo_empty;
    logic [LAB_REQ_W-1:0] fifo_dout;
    logic                 ev_bad_sel, ev_overflow, ev_timeout;

    assign wr_legal    = sel_legal(bus.wr_sel_i);
    assign fifo_push   = bus.wr_i && wr_legal && !flush_i;
    assign ev_bad_sel  = bus.wr_i && !wr_legal;
    assign ev_overflow = bus.wr_i && fifo_full;

    lab4d_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LAB_REQ_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush_i),
        .din_i   ({bus.wr_sel_i, bus.wr_dat_i}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        go_d       = 1'b0;
        sel_d      = sel_q;
        dat_d      = dat_q;
        fifo_pop   = 1'b0;
        ev_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A flush in the same cycle wins over the issue.
                if (!fifo_empty && !bus.busy_i && !flush_i) begin
                    fifo_pop       = 1'b1;
                    go_d           = 1'b1;
                    {sel_d, dat_d} = fifo_dout;
                    tmr_d          = TMR_LOAD;
                    state_d        = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (bus.busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (tmr_q == '0) begin
                    ev_timeout = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bad_sel_d  = (bad_sel_q  && !clr_err_i) || ev_bad_sel;
        overflow_d = (overflow_q && !clr_err_i) || ev_overflow;
        timeout_d  = (timeout_q  && !clr_err_i) || ev_timeout;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            go_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            bad_sel_q  <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            go_q       <= go_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            bad_sel_q  <= bad_sel_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.ready_o = !fifo_full;
    assign bus.go_o    = go_q;
    assign bus.sel_o   = sel_q;
    assign bus.dat_o   = dat_q;
    assign idle_o      = fifo_empty && (state_q == ST_IDLE);
    assign bad_sel_o   = bad_sel_q;
    assign overflow_o  = overflow_q;
    assign timeout_o   = timeout_q;

endmodule
